keypad_scanner: RTL and testbench

- Parametrised matrix-keypad scanner and debouncer for the calculator front end.
- Drives one-hot column strobes, samples the row inputs and rejects ghost (multi-key) patterns.
- Debounces press and release over whole scans, then emits one keycode per press on a valid/ready handshake to the calculator control FSM.
- Supersedes the fixed 4x4 combinational encoder; a 4x4 hex mapping is kept as a sub-module.

---
 rtl/keypad_pkg.sv | 25 ++
 rtl/keypad_keymap_4x4.sv | 12 +
 rtl/keypad_scanner.sv | 215 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner: FSM states, scan-result codes and the legacy 4x4 hex layout.
// Legacy layout rows: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESS_DB = 2'd1,
        ST_HELD     = 2'd2,
        ST_REL_DB   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_KEY   = 2'd1,
        RES_GHOST = 2'd2
    } scan_res_e;

    localparam logic [3:0] KEYMAP_4X4 [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

endpackage

// File: rtl/keypad_keymap_4x4.sv
// Key index (row*4+col) to legacy hex keycode for the 4x4 calculator keypad.
// Purely combinational, no handshake.
module keypad_keymap_4x4
    import keypad_pkg::*;
(
    input  logic [3:0] key_idx,
    output logic [3:0] hex_code
);

    assign hex_code = KEYMAP_4X4[key_idx];

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner/debouncer: one keycode per debounced press, ghost patterns rejected.
// Latency: key_valid rises 1 cycle after the scan end that completes the press debounce.
// Backpressure: key_valid holds until accepted; a press arriving while pending pulses overrun.
// Auto-repeat while held is built only with KEYPAD_REPEAT_EN defined.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int NUM_ROWS       = 4,
    parameter int NUM_COLS       = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_RATE    = 100,
    localparam int KW = (NUM_ROWS * NUM_COLS > 1) ? $clog2(NUM_ROWS * NUM_COLS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_ROWS-1:0] rows_in,
    output logic [NUM_COLS-1:0] col_drive,
    output logic                key_valid,
    output logic [KW-1:0]       key_code,
    input  logic                key_ready,
    output logic                overrun
);

    localparam int SW  = $clog2(SCAN_DIV);
    localparam int CIW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int STW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SW-1:0]  SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [CIW-1:0] COL_LAST  = CIW'(NUM_COLS - 1);
    localparam logic [STW-1:0] DB_DONE   = STW'(DEBOUNCE_SCANS);

    logic [NUM_ROWS-1:0] rows_meta_q, rows_sync_q;
    logic [SW-1:0]       slot_q, slot_d;
    logic [CIW-1:0]      col_idx_q, col_idx_d;
    logic [NUM_COLS-1:0] col_drive_q, col_drive_d;
    logic [1:0]          hits_q, hits_d, hits_acc;
    logic [KW-1:0]       idx_q, idx_d, idx_acc;
    state_e              state_q, state_d;
    logic [KW-1:0]       cand_q, cand_d;
    logic [STW-1:0]      stable_q, stable_d;
    logic                key_valid_q, key_valid_d;
    logic [KW-1:0]       key_code_q, key_code_d;
    logic                overrun_q, overrun_d;
    logic                slot_last, scan_end, is_cand, emit, accept;
    scan_res_e           scan_res;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW      = $clog2(REP_MAX + 1);
    localparam logic [RW-1:0] REP_DELAY_C = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_RATE_C  = RW'(REPEAT_RATE);
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_first_q, rep_first_d;
`else
    // Repeat timing has no effect in this build.
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_repeat_ignored
    end
`endif

    always_comb begin
        slot_last   = (slot_q == SLOT_LAST);
        scan_end    = slot_last && (col_idx_q == COL_LAST);
        slot_d      = slot_last ? '0 : slot_q + SW'(1);
        col_idx_d   = col_idx_q;
        col_drive_d = col_drive_q;
        if (slot_last) begin
            col_idx_d   = (col_idx_q == COL_LAST) ? '0 : col_idx_q + CIW'(1);
            col_drive_d = (col_idx_q == COL_LAST) ? NUM_COLS'(1) : col_drive_q << 1;
        end

        // Fold the current column into the scan; hits saturates at 2 (= ghost).
        hits_acc = hits_q;
        idx_acc  = idx_q;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (slot_last && rows_sync_q[r]) begin
                if (hits_acc == 2'd0) begin
                    hits_acc = 2'd1;
                    idx_acc  = KW'(r * NUM_COLS + int'(col_idx_q));
                end else begin
                    hits_acc = 2'd2;
                end
            end
        end
        hits_d = scan_end ? 2'd0 : hits_acc;
        idx_d  = scan_end ? '0 : idx_acc;
        scan_res = (hits_acc == 2'd0) ? RES_NONE : (hits_acc == 2'd1) ? RES_KEY : RES_GHOST;
        is_cand  = (scan_res == RES_KEY) && (idx_acc == cand_q);

        state_d  = state_q;
        cand_d   = cand_q;
        stable_d = stable_q;
        emit     = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
`endif
        if (scan_end) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_res == RES_KEY) begin
                        cand_d   = idx_acc;
                        stable_d = STW'(1);
                        if (stable_d == DB_DONE) begin
                            emit    = 1'b1;
                            state_d = ST_HELD;
                        end else begin
                            state_d = ST_PRESS_DB;
                        end
                    end
                end
                ST_PRESS_DB: begin
                    if (is_cand) begin
                        stable_d = stable_q + STW'(1);
                        if (stable_d == DB_DONE) begin
                            emit    = 1'b1;
                            state_d = ST_HELD;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (is_cand) begin
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt_d = rep_cnt_q + RW'(1);
                        if (rep_cnt_d == (rep_first_q ? REP_DELAY_C : REP_RATE_C)) begin
                            emit        = 1'b1;
                            rep_cnt_d   = '0;
                            rep_first_d = 1'b0;
                        end
`endif
                    end else begin
                        stable_d = STW'(1);
                        state_d  = (stable_d == DB_DONE) ? ST_IDLE : ST_REL_DB;
                    end
                end
                default: begin
                    if (is_cand) begin
                        state_d = ST_HELD;
                    end else begin
                        stable_d = stable_q + STW'(1);
                        if (stable_d == DB_DONE) state_d = ST_IDLE;
                    end
                end
            endcase
        end
`ifdef KEYPAD_REPEAT_EN
        if (state_d != ST_HELD || state_q != ST_HELD) begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
        end
`endif

        // An accept in the same cycle frees the slot for a new key.
        accept      = key_valid_q && key_ready;
        key_valid_d = key_valid_q && !accept;
        key_code_d  = key_code_q;
        overrun_d   = 1'b0;
        if (emit) begin
            if (!key_valid_q || accept) begin
                key_valid_d = 1'b1;
                key_code_d  = cand_d;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rows_meta_q <= '0;
            rows_sync_q <= '0;
            slot_q      <= '0;
            col_idx_q   <= '0;
            col_drive_q <= NUM_COLS'(1);
            hits_q      <= 2'd0;
            idx_q       <= '0;
            state_q     <= ST_IDLE;
            cand_q      <= '0;
            stable_q    <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            overrun_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
`endif
        end else begin
            rows_meta_q <= rows_in;
            rows_sync_q <= rows_meta_q;
            slot_q      <= slot_d;
            col_idx_q   <= col_idx_d;
            col_drive_q <= col_drive_d;
            hits_q      <= hits_d;
            idx_q       <= idx_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            stable_q    <= stable_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            overrun_q   <= overrun_d;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
`endif
        end
    end

    assign col_drive = col_drive_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (4x4, SCAN_DIV=4, DEBOUNCE_SCANS=2) with a behavioural keypad matrix.
module tb_keypad_scanner;

    localparam int SCAN_CYC = 16;
`ifdef KEYPAD_REPEAT_EN
    localparam int EXP_HOLD_EVENTS = 4;
`else
    localparam int EXP_HOLD_EVENTS = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  rows_in;
    logic [3:0]  col_drive;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_ready;
    logic        overrun;
    logic [3:0]  hex_code;
    logic [15:0] pressed;

    int n_tests = 0;
    int n_fail  = 0;
    int acc_cnt = 0;
    int ovr_cnt = 0;
    logic [3:0] last_code = 4'h0;

    keypad_scanner #(
        .NUM_ROWS(4), .NUM_COLS(4), .SCAN_DIV(4), .DEBOUNCE_SCANS(2),
        .REPEAT_DELAY(3), .REPEAT_RATE(2)
    ) dut (
        .clk(clk), .reset(reset), .rows_in(rows_in), .col_drive(col_drive),
        .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready), .overrun(overrun)
    );

    keypad_keymap_4x4 u_map (.key_idx(key_code), .hex_code(hex_code));

    always #5 clk = ~clk;

    // A pressed key shorts its row to the driven column.
    always_comb begin
        rows_in = '0;
        for (int r = 0; r < 4; r++) rows_in[r] = |(pressed[r*4 +: 4] & col_drive);
    end

    always @(posedge clk) begin
        if (!reset) begin
            if (key_valid && key_ready) begin
                acc_cnt   <= acc_cnt + 1;
                last_code <= key_code;
            end
            if (overrun) ovr_cnt <= ovr_cnt + 1;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic apply_scan(input logic [15:0] mask);
        pressed = mask;
        repeat (SCAN_CYC) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; pressed = '0; key_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n_tests += 4;
        if (col_drive !== 4'b0001) begin n_fail++; $display("FAIL rst_col got %b exp 0001", col_drive); end
        if (key_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", key_valid); end
        if (key_code !== 4'h0) begin n_fail++; $display("FAIL rst_code got %h exp 0", key_code); end
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun got %b exp 0", overrun); end
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (col_drive !== 4'b0010) begin n_fail++; $display("FAIL col_after4 got %b exp 0010", col_drive); end
        repeat (12) @(posedge clk);
        #1;
        n_tests++;
        if (col_drive !== 4'b0001) begin n_fail++; $display("FAIL col_wrap got %b exp 0001", col_drive); end
    endtask

    task automatic test_single_press();
        int a0;
        do_reset();
        key_ready = 1'b1;
        a0 = acc_cnt;
        apply_scan(16'h0040);
        n_tests++;
        if (key_valid !== 1'b0) begin n_fail++; $display("FAIL press_early got %b exp 0", key_valid); end
        apply_scan(16'h0040);
        n_tests += 3;
        if (key_valid !== 1'b1) begin n_fail++; $display("FAIL press_valid got %b exp 1", key_valid); end
        if (key_code !== 4'd6) begin n_fail++; $display("FAIL press_code got %0d exp 6", key_code); end
        if (hex_code !== 4'h6) begin n_fail++; $display("FAIL keymap_hex got %h exp 6", hex_code); end
        apply_scan(16'h0040);
        repeat (3) apply_scan(16'h0000);
        n_tests += 2;
        if (acc_cnt - a0 !== 1) begin n_fail++; $display("FAIL press_events got %0d exp 1", acc_cnt - a0); end
        if (last_code !== 4'd6) begin n_fail++; $display("FAIL press_accepted got %0d exp 6", last_code); end
    endtask

    task automatic test_bounce();
        int a0;
        bit pat [13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        key_ready = 1'b1;
        a0 = acc_cnt;
        for (int s = 0; s < 13; s++) begin
            apply_scan(pat[s] ? 16'h0400 : 16'h0000);
            if (s == 10) begin
                n_tests++;
                if (acc_cnt - a0 !== 1) begin n_fail++; $display("FAIL bounce_events got %0d exp 1", acc_cnt - a0); end
            end
            if (s == 11) begin
                n_tests++;
                if (key_valid !== 1'b0) begin n_fail++; $display("FAIL bounce_redb got %b exp 0", key_valid); end
            end
        end
        n_tests++;
        if (key_valid !== 1'b1) begin n_fail++; $display("FAIL bounce_repress got %b exp 1", key_valid); end
        apply_scan(16'h0000);
        n_tests++;
        if (acc_cnt - a0 !== 2) begin n_fail++; $display("FAIL bounce_total got %0d exp 2", acc_cnt - a0); end
    endtask

    task automatic test_ghost();
        int a0;
        logic seen;
        do_reset();
        key_ready = 1'b1;
        a0 = acc_cnt;
        seen = 1'b0;
        repeat (4) begin
            apply_scan(16'h0021);
            seen = seen | key_valid;
        end
        repeat (2) apply_scan(16'h0000);
        n_tests += 2;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL ghost_valid got %b exp 0", seen); end
        if (acc_cnt - a0 !== 0) begin n_fail++; $display("FAIL ghost_events got %0d exp 0", acc_cnt - a0); end
    endtask

    task automatic test_overrun();
        int o0;
        do_reset();
        key_ready = 1'b0;
        o0 = ovr_cnt;
        repeat (2) apply_scan(16'h0008);
        n_tests += 2;
        if (key_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_first_valid got %b exp 1", key_valid); end
        if (key_code !== 4'd3) begin n_fail++; $display("FAIL ovr_first_code got %0d exp 3", key_code); end
        repeat (2) apply_scan(16'h0000);
        repeat (2) apply_scan(16'h0200);
        n_tests += 2;
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_pulse got %b exp 1", overrun); end
        if (key_code !== 4'd3) begin n_fail++; $display("FAIL ovr_code_kept got %0d exp 3", key_code); end
        @(negedge clk);
        n_tests += 2;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_one_cycle got %b exp 0", overrun); end
        if (key_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_hold_valid got %b exp 1", key_valid); end
        key_ready = 1'b1;
        @(negedge clk);
        n_tests += 2;
        if (key_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got %b exp 0", key_valid); end
        if (ovr_cnt - o0 !== 1) begin n_fail++; $display("FAIL ovr_count got %0d exp 1", ovr_cnt - o0); end
    endtask

    task automatic test_back_to_back();
        int a0, o0;
        do_reset();
        key_ready = 1'b0;
        a0 = acc_cnt;
        o0 = ovr_cnt;
        repeat (2) apply_scan(16'h0008);
        repeat (2) apply_scan(16'h0000);
        apply_scan(16'h0200);
        repeat (SCAN_CYC - 1) @(posedge clk);
        @(negedge clk);
        key_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_tests += 3;
        if (key_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got %b exp 1", key_valid); end
        if (key_code !== 4'd9) begin n_fail++; $display("FAIL b2b_code got %0d exp 9", key_code); end
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun got %b exp 0", overrun); end
        @(negedge clk);
        n_tests += 3;
        if (key_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_clear got %b exp 0", key_valid); end
        if (acc_cnt - a0 !== 2) begin n_fail++; $display("FAIL b2b_events got %0d exp 2", acc_cnt - a0); end
        if (last_code !== 4'd9) begin n_fail++; $display("FAIL b2b_last got %0d exp 9", last_code); end
        pressed = '0;
    endtask

    task automatic test_reset_abort();
        int a0;
        do_reset();
        key_ready = 1'b1;
        apply_scan(16'h0040);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_tests += 3;
        if (col_drive !== 4'b0001) begin n_fail++; $display("FAIL abort_db_col got %b exp 0001", col_drive); end
        if (key_valid !== 1'b0) begin n_fail++; $display("FAIL abort_db_valid got %b exp 0", key_valid); end
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL abort_db_overrun got %b exp 0", overrun); end
        pressed = '0;
        reset = 1'b0;
        a0 = acc_cnt;
        repeat (3) apply_scan(16'h0000);
        n_tests++;
        if (acc_cnt - a0 !== 0) begin n_fail++; $display("FAIL abort_db_events got %0d exp 0", acc_cnt - a0); end

        key_ready = 1'b0;
        repeat (2) apply_scan(16'h0040);
        n_tests++;
        if (key_valid !== 1'b1) begin n_fail++; $display("FAIL abort_pend_setup got %b exp 1", key_valid); end
        reset = 1'b1;
        @(negedge clk);
        n_tests += 2;
        if (key_valid !== 1'b0) begin n_fail++; $display("FAIL abort_pend_valid got %b exp 0", key_valid); end
        if (key_code !== 4'h0) begin n_fail++; $display("FAIL abort_pend_code got %h exp 0", key_code); end
        pressed = '0;
        reset = 1'b0;
        a0 = acc_cnt;
        repeat (2) apply_scan(16'h0000);
        key_ready = 1'b1;
        @(negedge clk);
        n_tests += 2;
        if (key_valid !== 1'b0) begin n_fail++; $display("FAIL abort_after_valid got %b exp 0", key_valid); end
        if (acc_cnt - a0 !== 0) begin n_fail++; $display("FAIL abort_after_events got %0d exp 0", acc_cnt - a0); end
    endtask

    task automatic test_hold();
        int a0, o0;
        do_reset();
        key_ready = 1'b1;
        a0 = acc_cnt;
        o0 = ovr_cnt;
        repeat (10) apply_scan(16'h8000);
        repeat (3) apply_scan(16'h0000);
        n_tests += 3;
        if (acc_cnt - a0 !== EXP_HOLD_EVENTS) begin
            n_fail++; $display("FAIL hold_events got %0d exp %0d", acc_cnt - a0, EXP_HOLD_EVENTS);
        end
        if (last_code !== 4'd15) begin n_fail++; $display("FAIL hold_code got %0d exp 15", last_code); end
        if (ovr_cnt - o0 !== 0) begin n_fail++; $display("FAIL hold_overrun got %0d exp 0", ovr_cnt - o0); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_ghost();
        test_overrun();
        test_back_to_back();
        test_reset_abort();
        test_hold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
